// File: rtl/apb_slave_fifo.sv
// APB slave exposing a DEPTH-entry FIFO: DATA pushes/pops, STATUS reports occupancy, CTRL flushes.
// One wait state per transfer; FIFO side effects commit at the end of the PREADY cycle.
module apb_slave_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic [ADDR_WIDTH-1:0] i_PADDR,
  input  logic                  i_PSEL,
  input  logic                  i_PENABLE,
  input  logic                  i_PWRITE,
  input  logic [DATA_WIDTH-1:0] i_PWDATA,
  output logic                  o_PREADY,
  output logic [DATA_WIDTH-1:0] o_PRDATA,
  output logic                  o_PSLVERR,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_PUSH  = 2'd1,
    OP_POP   = 2'd2,
    OP_FLUSH = 2'd3
  } op_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;

  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;
  op_t                   r_op;
  logic [DATA_WIDTH-1:0] r_wdata;

  op_t                   w_op;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_slverr;
  logic [DATA_WIDTH-1:0] w_status;
  logic                  w_to_resp;
  logic                  w_commit;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_PSEL && !i_PENABLE) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (!i_PSEL)        w_state_nxt = S_IDLE;
        else if (i_PENABLE) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_to_resp = (r_state == S_SETUP) && i_PSEL && i_PENABLE;
  // Reset wins over a commit that coincides with it, so a reset during RESP drops the transfer.
  assign w_commit  = (r_state == S_RESP) && i_PSEL && i_PENABLE && !i_PRESET;

  // ---------------------------------------------------------------------------
  // Register decode: response and the FIFO action are decided in SETUP
  // ---------------------------------------------------------------------------
  always_comb begin
    w_status           = '0;
    w_status[CW+1:0]   = {r_count, r_full, r_empty};
  end

  always_comb begin
    w_op     = OP_NONE;
    w_rdata  = '0;
    w_slverr = 1'b0;
    unique case (i_PADDR)
      A_DATA: begin
        if (i_PWRITE) begin
          if (r_full) w_slverr = 1'b1;
          else        w_op     = OP_PUSH;
        end else begin
          if (r_empty) begin
            w_slverr = 1'b1;
          end else begin
            w_op    = OP_POP;
            w_rdata = r_mem[r_rd_ptr];
          end
        end
      end
      A_STATUS: begin
        if (i_PWRITE) w_slverr = 1'b1;
        else          w_rdata  = w_status;
      end
      A_CTRL: begin
        if (i_PWRITE && i_PWDATA[0]) w_op = OP_FLUSH;
      end
      default: begin
        w_slverr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_op      <= OP_NONE;
      r_wdata   <= '0;
    end else begin
      r_pready  <= w_to_resp;
      r_prdata  <= w_to_resp ? w_rdata : '0;
      r_pslverr <= w_to_resp && w_slverr;
      if (w_to_resp) begin
        r_op    <= w_op;
        r_wdata <= i_PWDATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  assign w_flush = w_commit && (r_op == OP_FLUSH);
  assign w_push  = w_commit && (r_op == OP_PUSH) && !r_full;
  assign w_pop   = w_commit && (r_op == OP_POP)  && !r_empty;

  always_ff @(posedge i_PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wdata;
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (w_push) begin
      r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_count  <= r_count + CW'(1);
      r_full   <= (r_count == CW'(DEPTH - 1));
      r_empty  <= 1'b0;
    end else if (w_pop) begin
      r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count  <= r_count - CW'(1);
      r_full   <= 1'b0;
      r_empty  <= (r_count == CW'(1));
    end
  end

  assign o_PREADY  = r_pready;
  assign o_PRDATA  = r_prdata;
  assign o_PSLVERR = r_pslverr;
  assign o_count   = r_count;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: tb/tb_apb_slave_fifo.sv
// Randomized scoreboard bench for apb_slave_fifo against a queue-based model of the register map.
module tb_apb_slave_fifo;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          o_pready;
  logic [DW-1:0] o_prdata;
  logic          o_pslverr;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  apb_slave_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .i_PCLK   (clk),
    .i_PRESET (rst),
    .i_PADDR  (paddr),
    .i_PSEL   (psel),
    .i_PENABLE(penable),
    .i_PWRITE (pwrite),
    .i_PWDATA (pwdata),
    .o_PREADY (o_pready),
    .o_PRDATA (o_prdata),
    .o_PSLVERR(o_pslverr),
    .o_count  (o_count),
    .o_full   (o_full),
    .o_empty  (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [DW-1:0] model[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every PREADY cycle consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_pready) begin
        if (sb.size() == 0) begin
          check("unexpected_pready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("prdata", 32'(o_prdata), 32'(e.data));
          check("pslverr", 32'(o_pslverr), 32'(e.err));
        end
      end else begin
        check("idle_prdata", 32'(o_prdata), 32'd0);
        check("idle_pslverr", 32'(o_pslverr), 32'd0);
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(o_count), 32'(model.size()));
    check({tag, "_full"},  32'(o_full),  32'(model.size() == DEPTH));
    check({tag, "_empty"}, 32'(o_empty), 32'(model.size() == 0));
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input bit rst_resp = 1'b0);
    exp_t e;
    int   op;
    int   lat;
    bit   seen;
    e  = '0;
    op = 0;
    if (addr == 16'h0000) begin
      if (wr) begin
        if (model.size() == DEPTH) e.err = 1'b1;
        else op = 1;
      end else begin
        if (model.size() == 0) e.err = 1'b1;
        else begin
          e.data = model[0];
          op     = 2;
        end
      end
    end else if (addr == 16'h0001) begin
      if (wr) e.err = 1'b1;
      else e.data = DW'(model.size() * 4 + ((model.size() == DEPTH) ? 2 : 0)
                        + ((model.size() == 0) ? 1 : 0));
    end else if (addr == 16'h0002) begin
      if (wr && wdata[0]) op = 3;
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);

    @(posedge clk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_pready) seen = 1'b1;
    end
    if (!seen) begin
      check("pready_timeout", 32'd0, 32'd1);
      psel    = 1'b0;
      penable = 1'b0;
      return;
    end
    check("latency", 32'(lat), 32'd2);
    pwdata = DW'($urandom);
    if (rst_resp) rst = 1'b1;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    if (rst_resp) begin
      rst = 1'b0;
      model.delete();
    end else begin
      case (op)
        1: model.push_back(wdata);
        2: void'(model.pop_front());
        3: model.delete();
        default: ;
      endcase
    end
    check("pready_drop", 32'(o_pready), 32'd0);
    check_status("post");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int r;
    logic [DW-1:0] d;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 32'(o_pready), 32'd0);
    check("rst_prdata", 32'(o_prdata), 32'd0);
    check("rst_pslverr", 32'(o_pslverr), 32'd0);
    check_status("rst");
    rst    = 1'b0;
    mon_en = 1'b1;

    xfer(16'h0001, 1'b0, '0);
    for (int i = 1; i <= 3; i++) xfer(16'h0000, 1'b1, DW'(16'hA000 + i));
    for (int i = 0; i < 3; i++) xfer(16'h0000, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) xfer(16'h0000, 1'b1, DW'(16'hB000 + i));
    xfer(16'h0001, 1'b0, '0);
    xfer(16'h0000, 1'b1, 16'hDEAD);
    xfer(16'h0002, 1'b1, 16'h0001);

    xfer(16'h0000, 1'b0, '0);
    xfer(16'h0005, 1'b1, 16'h1234);
    xfer(16'h0001, 1'b1, 16'h00FF);
    xfer(16'h1000, 1'b0, '0);
    xfer(16'h8002, 1'b1, 16'h0001);
    xfer(16'h0000, 1'b1, 16'h5A5A);
    xfer(16'h0002, 1'b1, 16'hFFFE);
    xfer(16'h0002, 1'b0, '0);
    xfer(16'h0002, 1'b1, 16'h0001);

    for (int i = 0; i < 6; i++) xfer(16'h0000, 1'b1, DW'(16'hC000 + i));
    for (int i = 0; i < 6; i++) xfer(16'h0000, 1'b0, '0);
    for (int i = 0; i < 5; i++) xfer(16'h0000, 1'b1, DW'(16'hC100 + i));
    for (int i = 0; i < 5; i++) xfer(16'h0000, 1'b0, '0);

    for (int i = 0; i < 3; i++) xfer(16'h0000, 1'b1, DW'(16'hD000 + i));
    xfer(16'h0002, 1'b1, 16'h0001);
    xfer(16'h0000, 1'b1, 16'hE000);
    xfer(16'h0000, 1'b1, 16'hE001);
    xfer(16'h0000, 1'b1, 16'hE002, 1'b1);
    xfer(16'h0000, 1'b0, '0);

    // Abandoned setup phase: no response and no side effect.
    xfer(16'h0000, 1'b1, 16'hF00D);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0000; pwrite = 1'b1; pwdata = 16'hBAD0;
    @(posedge clk); #1;
    psel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_status("abort");

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      d = DW'($urandom);
      if (r <= 3)      xfer(16'h0000, 1'b1, d, ($urandom_range(0, 39) == 0));
      else if (r <= 6) xfer(16'h0000, 1'b0, '0);
      else if (r == 7) xfer(16'h0001, 1'b0, '0);
      else if (r == 8) xfer(16'h0002, 1'b1, (d & 16'hFFFE) | DW'($urandom_range(0, 3) == 0));
      else             xfer(AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
